// File: rtl/mems_dac_spi_tx_if.sv
// Handshake and SPI pin bundle between the MEMS control sequencer and the DAC transmitter.
// The master side issues start/data_in; the slave side (transmitter) drives status and SPI pins.
interface mems_dac_spi_tx_if #(
    parameter int WORD_BITS = 24
);
    logic                 start;
    logic [WORD_BITS-1:0] data_in;
    logic                 busy;
    logic                 done;
    logic                 sclk;
    logic                 mosi;
    logic                 sync_n;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  sclk,
        input  mosi,
        input  sync_n
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output sclk,
        output mosi,
        output sync_n
    );
endinterface

// File: rtl/mems_dac_spi_tx.sv
// SPI transmitter for the MEMS mirror DAC: one start pulse sends one MSB-first 24-bit frame
// under an active-low SYNC, with busy covering the load, shift and SYNC-high recovery.
module mems_dac_spi_tx #(
    parameter int CLK_DIV   = 2,
    parameter int WORD_BITS = 24,
    parameter int SYNC_HIGH = 2
) (
    input  logic clk,
    input  logic rst,
    mems_dac_spi_tx_if.slave bus
);

    localparam int BIT_W  = $clog2(WORD_BITS) + 1;
    localparam int HALF_W = $clog2(CLK_DIV) + 1;
    localparam int HOLD_W = $clog2(SYNC_HIGH) + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SYNC_HIGH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t               state_r,    state_s;
    logic                 busy_r,     busy_s;
    logic                 done_r,     done_s;
    logic                 sclk_r,     sclk_s;
    logic                 mosi_r,     mosi_s;
    logic                 sync_n_r,   sync_n_s;
    logic [WORD_BITS-1:0] shift_r,    shift_s;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_cnt_s;
    logic [HALF_W-1:0]    half_cnt_r, half_cnt_s;
    logic [HOLD_W-1:0]    hold_cnt_r, hold_cnt_s;

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        sclk_s     = sclk_r;
        mosi_s     = mosi_r;
        sync_n_s   = sync_n_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        half_cnt_s = half_cnt_r;
        hold_cnt_s = hold_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_LOAD;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            // ROM data arrives one cycle after start, so the word is captured here.
            ST_LOAD: begin
                shift_s    = bus.data_in;
                mosi_s     = bus.data_in[WORD_BITS-1];
                sync_n_s   = 1'b0;
                sclk_s     = 1'b1;
                bit_cnt_s  = {BIT_W{1'b0}};
                half_cnt_s = {HALF_W{1'b0}};
                state_s    = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (half_cnt_r == HALF_LAST) begin
                    half_cnt_s = {HALF_W{1'b0}};
                    if (sclk_r) begin
                        sclk_s = 1'b0;
                    end else begin
                        // Rising edge closes the current bit; mosi only moves here.
                        sclk_s    = 1'b1;
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                        if (bit_cnt_r == BIT_LAST) begin
                            sync_n_s   = 1'b1;
                            hold_cnt_s = {HOLD_W{1'b0}};
                            state_s    = ST_HOLD;
                        end else begin
                            shift_s = {shift_r[WORD_BITS-2:0], 1'b0};
                            mosi_s  = shift_r[WORD_BITS-2];
                        end
                    end
                end else begin
                    half_cnt_s = half_cnt_r + HALF_W'(1);
                end
            end

            ST_HOLD: begin
                sclk_s   = 1'b1;
                sync_n_s = 1'b1;
                if (hold_cnt_r == HOLD_LAST) begin
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    hold_cnt_s = {HOLD_W{1'b0}};
                    state_s    = ST_IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end

            default: begin
                state_s  = ST_IDLE;
                busy_s   = 1'b0;
                sclk_s   = 1'b1;
                sync_n_s = 1'b1;
            end
        endcase
    end

    // State and output registers; an asserted reset drops the frame on the spot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sclk_r     <= 1'b1;
            mosi_r     <= 1'b0;
            sync_n_r   <= 1'b1;
            shift_r    <= {WORD_BITS{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            half_cnt_r <= {HALF_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            sclk_r     <= sclk_s;
            mosi_r     <= mosi_s;
            sync_n_r   <= sync_n_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            half_cnt_r <= half_cnt_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.sclk   = sclk_r;
    assign bus.mosi   = mosi_r;
    assign bus.sync_n = sync_n_r;

endmodule

// File: doc/mems_dac_spi_tx.md
Name: mems_dac_spi_tx

Overview:
- SPI transmitter for the MEMS mirror DAC, on the far side of the mems_SPI_start / mems_SPI_busy handshake driven by the MEMS control sequencer.
- On each start pulse, captures the 24-bit command word read from the scan ROM and shifts it out MSB-first, framed by an active-low SYNC.
- Holds busy for the whole transaction, including the SYNC-high recovery time.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period (≥1).
- WORD_BITS, 24: bits per DAC frame.
- SYNC_HIGH, 2: minimum clk cycles SYNC stays high between frames (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous assert, active-low.
- start  input  1  one-cycle request pulse (mems_SPI_start).
- data_in  input  WORD_BITS  DAC command word from scan ROM.
- busy  output  1  transaction in progress (mems_SPI_busy).
- done  output  1  one-cycle pulse when a frame is complete.
- sclk  output  1  SPI clock; idles high.
- mosi  output  1  SPI data.
- sync_n  output  1  DAC frame select; active-low.

Behaviour:
- Reset (rst=0, async) values: state=IDLE, busy=0, done=0, sclk=1, mosi=0, sync_n=1, shift register=0, counters=0. Reset mid-frame aborts the frame immediately, with no partial completion and no done pulse.
- All outputs are registered. No combinational path from input to output.
- States and transitions:
  - IDLE: on a clk edge with start=1, go to LOAD and set busy=1. The sequencer therefore sees busy=1 in the cycle after its start pulse.
  - LOAD (1 cycle): capture data_in into the shift register. The ROM has 1-cycle read latency, and its address changed alongside start. Set sync_n=0 and mosi=data_in[WORD_BITS-1]. Go to SHIFT.
  - SHIFT, per bit:
    - sclk high for CLK_DIV cycles, then low for CLK_DIV cycles. The DAC samples on the falling edge.
    - mosi updates to the next bit on the edge where sclk returns high.
    - After bit 0's low phase, sclk returns high, sync_n goes high, and the state moves to HOLD.
  - HOLD: sync_n=1 and sclk=1 for SYNC_HIGH cycles. On the last cycle, busy goes low and done=1 for one cycle. Return to IDLE.
- Busy duration per frame: 1 + WORD_BITS·2·CLK_DIV + SYNC_HIGH cycles. With defaults this is 1 + 96 + 2 = 99.
- start while busy=1 (any non-IDLE state) is ignored. It is neither queued nor allowed to corrupt the frame.
- A new start in the same cycle that busy falls (the first IDLE cycle) is accepted normally. Back-to-back frames are separated by at least SYNC_HIGH cycles of sync_n=1.
- data_in is sampled only in LOAD. Changes at any other time have no effect.
- mosi is held at the last bit value after the frame and returns to 0 only on reset.
- Bit counter width is clog2(WORD_BITS)+1. The half-period counter width is clog2(CLK_DIV)+1. Neither wraps within a frame.

Test Plan:
- Reset release, no start for 20 cycles → busy=0, sclk=1, sync_n=1, mosi=0, done=0 throughout.
- start pulse with data_in=0x3F8000 valid the following cycle → busy=1 in the cycle after start. On the 24 sclk falling edges, mosi reads 0x3F8000 MSB-first. sync_n is low for exactly 96 cycles. done pulses at cycle 99, and busy falls at the same time.
- start re-pulsed at cycles 10 and 50 of an active frame → the frame is unchanged, and exactly one done pulse occurs.
- Sequencer-style back-to-back: start asserted in the first cycle busy=0, with data 0x280001 then 0x2000FF → two correct frames with sync_n high for ≥2 cycles between them. Total 198 busy cycles.
- rst driven low asynchronously mid-frame (bit 12) → sync_n=1, sclk=1, busy=0 without waiting for a clk edge. No done pulse. A start after release transmits a full, correct 24-bit frame.
- CLK_DIV=1, SYNC_HIGH=1, data 0xAAAAAA → sclk period 2 cycles, mosi alternating, busy length 1+48+1=50 cycles.
